// File: rtl/pixel_collision_detector.sv
// Watches the bird/pipe render layers per scan position, counts overlap pixels per frame
// and latches a sticky collision flag (with cause) once a hit condition holds for enough frames.
module pixel_collision_detector #(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int GROUND_Y       = 440,
    parameter int HIT_THRESHOLD  = 4,
    parameter int CONFIRM_FRAMES = 2,
    parameter int GRACE_FRAMES   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        bird_pixel,
    input  logic        pipe_pixel,
    input  logic        clear,
    output logic        collision,
    output logic        hit_pipe,
    output logic        hit_ground,
    output logic        frame_tick,
    output logic [15:0] overlap_count,
    output logic [1:0]  dbg_state_o
);

    localparam int GW = $clog2(GRACE_FRAMES) + 1;
    localparam int CW = $clog2(CONFIRM_FRAMES) + 1;

    // Debug encoding of dbg_state_o: 0 = GRACE, 1 = ARMED, 2 = HIT.
    typedef enum logic [1:0] {
        ST_GRACE = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIT   = 2'd2
    } state_t;

    state_t          state_q;
    logic [9:0]      prev_h_q, prev_v_q;
    logic [15:0]     ovl_acc_q, ovl_acc_d;
    logic            gnd_seen_q, gnd_seen_d;
    logic            bird_seen_q, bird_seen_d;
    logic [GW-1:0]   grace_cnt_q;
    logic [CW-1:0]   confirm_cnt_q, confirm_inc;
    logic            pend_pipe_q, pend_gnd_q;
    logic            collision_q, hit_pipe_q, hit_ground_q, frame_tick_q;
    logic [15:0]     overlap_q;

    logic new_pix, active, boundary, ovl_hit, bird_act, gnd_hit;
    logic pipe_ok, gnd_ok, grace_done, confirm_done;

    // A sample is a change of scan position, so any clk/pixel ratio counts each pixel once.
    always_comb begin
        new_pix      = (hCount != prev_h_q) || (vCount != prev_v_q);
        active       = new_pix && ({1'b0, hCount} < 11'(H_ACTIVE)) && ({1'b0, vCount} < 11'(V_ACTIVE));
        boundary     = new_pix && (vCount == 10'd0) && (prev_v_q != 10'd0);
        ovl_hit      = active && bird_pixel && pipe_pixel;
        bird_act     = active && bird_pixel;
        gnd_hit      = bird_act && ({1'b0, vCount} >= 11'(GROUND_Y));
        pipe_ok      = ovl_acc_q >= 16'(HIT_THRESHOLD);
        gnd_ok       = gnd_seen_q || !bird_seen_q;
        grace_done   = (GRACE_FRAMES == 0) || (grace_cnt_q == GW'(GRACE_FRAMES - 1));
        confirm_inc  = confirm_cnt_q + CW'(1);
        confirm_done = confirm_inc >= CW'(CONFIRM_FRAMES);

        ovl_acc_d   = ovl_acc_q;
        gnd_seen_d  = gnd_seen_q || gnd_hit;
        bird_seen_d = bird_seen_q || bird_act;
        if (boundary) begin
            // The boundary pixel is the first sample of the new frame.
            ovl_acc_d   = {15'd0, ovl_hit};
            gnd_seen_d  = gnd_hit;
            bird_seen_d = bird_act;
        end else if (ovl_hit && (ovl_acc_q != 16'hFFFF)) begin
            ovl_acc_d = ovl_acc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_GRACE;
            prev_h_q      <= 10'h3FF;
            prev_v_q      <= 10'h3FF;
            ovl_acc_q     <= 16'd0;
            gnd_seen_q    <= 1'b0;
            bird_seen_q   <= 1'b0;
            grace_cnt_q   <= '0;
            confirm_cnt_q <= '0;
            pend_pipe_q   <= 1'b0;
            pend_gnd_q    <= 1'b0;
            collision_q   <= 1'b0;
            hit_pipe_q    <= 1'b0;
            hit_ground_q  <= 1'b0;
            frame_tick_q  <= 1'b0;
            overlap_q     <= 16'd0;
        end else begin
            prev_h_q     <= hCount;
            prev_v_q     <= vCount;
            ovl_acc_q    <= ovl_acc_d;
            gnd_seen_q   <= gnd_seen_d;
            bird_seen_q  <= bird_seen_d;
            frame_tick_q <= boundary;
            if (boundary) begin
                overlap_q <= ovl_acc_q;
            end

            // clear outranks a coincident boundary; the frame bookkeeping above still runs.
            if (clear) begin
                state_q       <= ST_GRACE;
                grace_cnt_q   <= '0;
                confirm_cnt_q <= '0;
                pend_pipe_q   <= 1'b0;
                pend_gnd_q    <= 1'b0;
                collision_q   <= 1'b0;
                hit_pipe_q    <= 1'b0;
                hit_ground_q  <= 1'b0;
            end else if (boundary) begin
                case (state_q)
                    ST_GRACE: begin
                        if (grace_done) begin
                            state_q       <= ST_ARMED;
                            grace_cnt_q   <= '0;
                            confirm_cnt_q <= '0;
                            pend_pipe_q   <= 1'b0;
                            pend_gnd_q    <= 1'b0;
                        end else begin
                            grace_cnt_q <= grace_cnt_q + GW'(1);
                        end
                    end
                    ST_ARMED: begin
                        if (pipe_ok || gnd_ok) begin
                            confirm_cnt_q <= confirm_inc;
                            pend_pipe_q   <= pend_pipe_q || pipe_ok;
                            pend_gnd_q    <= pend_gnd_q || gnd_ok;
                            if (confirm_done) begin
                                state_q      <= ST_HIT;
                                collision_q  <= 1'b1;
                                hit_pipe_q   <= pend_pipe_q || pipe_ok;
                                hit_ground_q <= pend_gnd_q || gnd_ok;
                            end
                        end else begin
                            confirm_cnt_q <= '0;
                            pend_pipe_q   <= 1'b0;
                            pend_gnd_q    <= 1'b0;
                        end
                    end
                    ST_HIT: begin
                        state_q <= ST_HIT;
                    end
                    default: begin
                        state_q <= ST_GRACE;
                    end
                endcase
            end
        end
    end

    assign collision     = collision_q;
    assign hit_pipe      = hit_pipe_q;
    assign hit_ground    = hit_ground_q;
    assign frame_tick    = frame_tick_q;
    assign overlap_count = overlap_q;
    assign dbg_state_o   = state_q;

endmodule
